// File: rtl/read_addr_accept_pkg.sv
// read_addr_accept_pkg: burst-type constants, AR entry field order and beat-size limit helper
package read_addr_accept_pkg;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;
  // Queue entries are packed MSB-first as {id, addr, len, size, burst}.
  // Largest legal arsize for a data bus of dw bits: log2(dw/8).
  function automatic int max_size(input int dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/read_addr_accept_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count; storage is not cleared by reset
// Ports: clk, reset (sync, active-low), push/din write, pop/dout read head, count/full/empty status.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk) if (push) mem[wp] <= din;
  assign dout = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/read_addr_accept.sv
// read_addr_accept: AXI AR acceptor that sanitises size/burst and queues requests for data_read
// Ports: AR slave channel (arid..arvalid/arready), head-entry payload *_out with mod1_valid_out/mod1_ready_in,
// sticky ar_err for sanitised requests, occupancy of the queue. Reset is synchronous, active-low.
module read_addr_accept
  import read_addr_accept_pkg::*;
#(
  parameter int ADD_WIDTH    = 32,
  parameter int ADD_ID_WIDTH = 4,
  parameter int BURST_LEN    = 8,
  parameter int BURST_SIZE   = 3,
  parameter int BURST_TYPE   = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADD_ID_WIDTH-1:0]       arid,
  input  logic [ADD_WIDTH-1:0]          araddr,
  input  logic [BURST_LEN-1:0]          arlen,
  input  logic [BURST_SIZE-1:0]         arsize,
  input  logic [BURST_TYPE-1:0]         arburst,
  input  logic                          arvalid,
  output logic                          arready,
  output logic [ADD_ID_WIDTH-1:0]       rid_out,
  output logic [ADD_WIDTH-1:0]          raddr_out,
  output logic [BURST_LEN-1:0]          rlen_out,
  output logic [BURST_SIZE-1:0]         rsize_out,
  output logic [BURST_TYPE-1:0]         rburst_out,
  output logic                          mod1_valid_out,
  input  logic                          mod1_ready_in,
  output logic                          ar_err,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);
  localparam int EW = ADD_ID_WIDTH + ADD_WIDTH + BURST_LEN + BURST_SIZE + BURST_TYPE;
  localparam logic [BURST_SIZE-1:0] MAXS = BURST_SIZE'(max_size(DATA_WIDTH));
  logic size_bad, rsvd_bad, wrap_bad, push, pop, full, empty;
  logic [BURST_SIZE-1:0] size_s;
  logic [BURST_TYPE-1:0] burst_s;
  logic [EW-1:0] din, dout;
  assign size_bad = arsize > MAXS;
  assign rsvd_bad = arburst == BURST_TYPE'(BURST_RSVD);
  // WRAP bursts must span 2, 4, 8 or 16 beats; anything else degrades to INCR.
  assign wrap_bad = arburst == BURST_TYPE'(BURST_WRAP) &&
                    !(arlen == BURST_LEN'(1) || arlen == BURST_LEN'(3) ||
                      arlen == BURST_LEN'(7) || arlen == BURST_LEN'(15));
  assign size_s = size_bad ? MAXS : arsize;
  assign burst_s = (rsvd_bad || wrap_bad) ? BURST_TYPE'(BURST_INCR) : arburst;
  assign din = {arid, araddr, arlen, size_s, burst_s};
  // Handshakes decode only registered state, so ready never depends on valid across the block.
  assign arready = reset && !full;
  assign mod1_valid_out = !empty;
  assign push = arvalid && arready;
  assign pop = mod1_valid_out && mod1_ready_in;
  assign {rid_out, raddr_out, rlen_out, rsize_out, rburst_out} = empty ? '0 : dout;
  always_ff @(posedge clk) begin
    if (!reset) ar_err <= 1'b0;
    else if (push && (size_bad || rsvd_bad || wrap_bad)) ar_err <= 1'b1;
  end
  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .count (occupancy),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_read_addr_accept.sv
// tb_read_addr_accept: directed and table-driven checks of the AR acceptor at DATA_WIDTH 32, depth 4
module tb_read_addr_accept;
  logic clk = 0, reset = 0;
  logic [3:0] arid = 0;
  logic [31:0] araddr = 0;
  logic [7:0] arlen = 0;
  logic [2:0] arsize = 0;
  logic [1:0] arburst = 0;
  logic arvalid = 0, mod1_ready_in = 0;
  logic arready, mod1_valid_out, ar_err;
  logic [3:0] rid_out;
  logic [31:0] raddr_out;
  logic [7:0] rlen_out;
  logic [2:0] rsize_out;
  logic [1:0] rburst_out;
  logic [2:0] occupancy;
  int checks = 0, errors = 0;

  read_addr_accept #(
    .ADD_WIDTH(32), .ADD_ID_WIDTH(4), .BURST_LEN(8), .BURST_SIZE(3),
    .BURST_TYPE(2), .DATA_WIDTH(32), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid_out(rid_out), .raddr_out(raddr_out), .rlen_out(rlen_out),
    .rsize_out(rsize_out), .rburst_out(rburst_out), .mod1_valid_out(mod1_valid_out),
    .mod1_ready_in(mod1_ready_in), .ar_err(ar_err), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic [3:0] id;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [2:0] esize;
    logic [1:0] eburst;
    logic eerr;
  } vec_t;
  vec_t vec[9];

  typedef logic [48:0] ent_t;
  ent_t q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] id, input logic [31:0] a, input logic [7:0] l,
                       input logic [2:0] s, input logic [1:0] b);
    arid = id; araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1;
  endtask

  initial begin
    vec[0] = '{0, 4'd1, 8'd3,  3'd2, 2'd1, 3'd2, 2'd1, 1'b0};
    vec[1] = '{0, 4'd2, 8'd7,  3'd1, 2'd2, 3'd1, 2'd2, 1'b0};
    vec[2] = '{0, 4'd3, 8'd0,  3'd0, 2'd0, 3'd0, 2'd0, 1'b0};
    vec[3] = '{0, 4'd4, 8'd1,  3'd2, 2'd2, 3'd2, 2'd2, 1'b0};
    vec[4] = '{0, 4'd5, 8'd3,  3'd3, 2'd1, 3'd2, 2'd1, 1'b1};
    vec[5] = '{1, 4'd6, 8'd0,  3'd0, 2'd3, 3'd0, 2'd1, 1'b1};
    vec[6] = '{1, 4'd7, 8'd5,  3'd2, 2'd2, 3'd2, 2'd1, 1'b1};
    vec[7] = '{1, 4'd8, 8'd15, 3'd7, 2'd2, 3'd2, 2'd2, 1'b1};
    vec[8] = '{1, 4'd9, 8'd15, 3'd2, 2'd2, 3'd2, 2'd2, 1'b0};

    // reset state
    step();
    chk("rst_arready", arready, 0);
    chk("rst_valid", mod1_valid_out, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_err", ar_err, 0);
    chk("rst_payload", {rid_out, raddr_out, rlen_out, rsize_out, rburst_out}, 0);
    reset = 1;
    #1;
    chk("post_rst_arready", arready, 1);

    // single request
    drive(4'd3, 32'h100, 8'd3, 3'd2, 2'd1);
    mod1_ready_in = 1;
    step();
    arvalid = 0;
    chk("single_valid", mod1_valid_out, 1);
    chk("single_payload", {rid_out, raddr_out, rlen_out, rsize_out, rburst_out},
        {4'd3, 32'h100, 8'd3, 3'd2, 2'd1});
    step();
    mod1_ready_in = 0;
    chk("single_empty", mod1_valid_out, 0);
    chk("single_zero", {rid_out, raddr_out, rlen_out, rsize_out, rburst_out}, 0);
    chk("single_occ", occupancy, 0);

    // fill, hold off a fifth request, then pop one
    for (int i = 0; i < 4; i++) begin
      drive(4'(i + 1), 32'h200 + 32'(i * 16), 8'd0, 3'd2, 2'd1);
      step();
    end
    drive(4'd9, 32'h300, 8'd0, 3'd2, 2'd1);
    chk("fill_occ", occupancy, 4);
    chk("fill_arready", arready, 0);
    step();
    chk("fill_held_occ", occupancy, 4);
    chk("fill_head", rid_out, 1);
    mod1_ready_in = 1;
    #1;
    chk("full_pop_arready", arready, 0);
    step();
    mod1_ready_in = 0;
    chk("after_pop_occ", occupancy, 3);
    chk("after_pop_arready", arready, 1);
    step();
    arvalid = 0;
    chk("refill_occ", occupancy, 4);
    mod1_ready_in = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", rid_out, (i < 3) ? 64'(i + 2) : 64'd9);
      step();
    end
    mod1_ready_in = 0;
    chk("drain_empty", occupancy, 0);

    // steady push+pop at occupancy 2
    q.delete();
    for (int i = 0; i < 2; i++) begin
      drive(4'(10 + i), 32'h0, 8'd0, 3'd0, 2'd1);
      q.push_back({4'(10 + i), 32'h0, 8'd0, 3'd0, 2'd1});
      step();
    end
    mod1_ready_in = 1;
    for (int k = 0; k < 10; k++) begin
      drive(4'((12 + k) % 16), 32'h0, 8'd0, 3'd0, 2'd1);
      q.push_back({4'((12 + k) % 16), 32'h0, 8'd0, 3'd0, 2'd1});
      chk("stream_id", rid_out, q[0][48:45]);
      void'(q.pop_front());
      step();
      chk("stream_occ", occupancy, 2);
    end
    arvalid = 0;
    for (int i = 0; i < 2; i++) begin
      chk("stream_tail", rid_out, q[0][48:45]);
      void'(q.pop_front());
      step();
    end
    mod1_ready_in = 0;

    // sanitising table
    for (int i = 0; i < 9; i++) begin
      if (vec[i].rst) begin
        reset = 0;
        step();
        reset = 1;
      end
      drive(vec[i].id, 32'h40, vec[i].len, vec[i].size, vec[i].burst);
      step();
      arvalid = 0;
      chk("vec_valid", mod1_valid_out, 1);
      chk("vec_id", rid_out, vec[i].id);
      chk("vec_size", rsize_out, vec[i].esize);
      chk("vec_burst", rburst_out, vec[i].eburst);
      chk("vec_err", ar_err, vec[i].eerr);
      mod1_ready_in = 1;
      step();
      mod1_ready_in = 0;
    end

    // reset mid-operation
    drive(4'd1, 32'h10, 8'd0, 3'd3, 2'd1);
    step();
    drive(4'd2, 32'h20, 8'd0, 3'd1, 2'd1);
    step();
    drive(4'd3, 32'h30, 8'd0, 3'd1, 2'd1);
    step();
    arvalid = 0;
    chk("mid_occ", occupancy, 3);
    chk("mid_err", ar_err, 1);
    reset = 0;
    step();
    chk("mid_rst_valid", mod1_valid_out, 0);
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_err", ar_err, 0);
    chk("mid_rst_arready", arready, 0);
    reset = 1;
    #1;
    chk("mid_after_arready", arready, 1);
    chk("mid_after_valid", mod1_valid_out, 0);

    // random back-pressure with scoreboard
    begin
      int acc, got;
      logic p, o;
      q.delete();
      acc = 0;
      got = 0;
      for (int c = 0; c < 1000; c++) begin
        arid = 4'($urandom);
        araddr = $urandom;
        arlen = 8'($urandom);
        arsize = 3'($urandom_range(0, 2));
        arburst = 2'($urandom_range(0, 1));
        arvalid = 1'($urandom);
        mod1_ready_in = 1'($urandom);
        #1;
        p = arvalid && arready;
        o = mod1_valid_out && mod1_ready_in;
        if (occupancy == 4) chk("rand_full_arready", arready, 0);
        if (o) begin
          if (q.size() == 0) chk("rand_spurious", 1, 0);
          else begin
            chk("rand_entry", {rid_out, raddr_out, rlen_out, rsize_out, rburst_out}, q[0]);
            void'(q.pop_front());
          end
          got++;
        end
        if (p) begin
          q.push_back({arid, araddr, arlen, arsize, arburst});
          acc++;
        end
        @(posedge clk);
        #1;
      end
      arvalid = 0;
      mod1_ready_in = 1;
      for (int c = 0; c < 20 && mod1_valid_out; c++) begin
        chk("rand_drain", {rid_out, raddr_out, rlen_out, rsize_out, rburst_out}, q[0]);
        void'(q.pop_front());
        got++;
        step();
      end
      mod1_ready_in = 0;
      chk("rand_count", got, acc);
      chk("rand_left", q.size(), 0);
      chk("rand_empty", mod1_valid_out, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
